sequenciador_menor_distancia: RTL

Sequential nearest-template classifier controller. Requests the distance for each of the 10 digit templates, one at a time, from a shared distance unit. Tracks the running minimum distance and its index (argmin). Reports the winning digit, or 15 when the best distance exceeds a rejection threshold. Sits between the frame/feature capture logic (which pulses start) and the HUD/game logic (which consumes the digit).

---
 rtl/sequenciador_menor_distancia_pkg.sv | 17 +
 rtl/sequenciador_menor_distancia_if.sv | 26 ++
 rtl/sequenciador_menor_distancia_acumulador.sv | 45 ++++
 rtl/sequenciador_menor_distancia.sv | 119 +++++++++++
 4 files changed

// File: rtl/sequenciador_menor_distancia_pkg.sv
// Shared types and defaults for the nearest-template classifier.
// The sequencer FSM states and the rejected-digit code live here.
package classificacao_pkg;

  localparam int N_CLASSES_DEF = 10;
  localparam int DIST_W_DEF    = 16;

  localparam logic [3:0] DIGITO_INVALIDO = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DECIDE
  } estado_t;

endpackage

// File: rtl/sequenciador_menor_distancia_if.sv
// Start/request/result bundle between capture logic, distance unit and HUD.
// The slave modport is the sequencer's view; master is the environment's.
interface sequenciador_menor_distancia_if #(
  parameter int DIST_W = 16
);
  logic              iStart;
  logic [DIST_W-1:0] iLimiar;
  logic              oReq;
  logic [3:0]        oTemplate;
  logic              iDistValid;
  logic [DIST_W-1:0] iDist;
  logic              oBusy;
  logic              oDone;
  logic [3:0]        oDigito;
  logic [DIST_W-1:0] oMenorDist;

  modport master (
    output iStart, iLimiar, iDistValid, iDist,
    input  oReq, oTemplate, oBusy, oDone, oDigito, oMenorDist
  );

  modport slave (
    input  iStart, iLimiar, iDistValid, iDist,
    output oReq, oTemplate, oBusy, oDone, oDigito, oMenorDist
  );
endinterface

// File: rtl/sequenciador_menor_distancia_acumulador.sv
// Running minimum / argmin register pair. Strict less-than update, so ties
// keep the earlier (lower) index.
module acumulador_menor #(
  parameter int DIST_W = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DIST_W-1:0] valor_i,
  input  logic [IDX_W-1:0]  indice_i,
  output logic [DIST_W-1:0] min_o,
  output logic [IDX_W-1:0]  argmin_o
);

  logic [DIST_W-1:0] min_q, min_d;
  logic [IDX_W-1:0]  arg_q, arg_d;

  always_comb begin
    min_d = min_q;
    arg_d = arg_q;
    if (clr_i) begin
      min_d = '1;
      arg_d = '0;
    end else if (en_i && (valor_i < min_q)) begin
      min_d = valor_i;
      arg_d = indice_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      min_q <= '1;
      arg_q <= '0;
    end else begin
      min_q <= min_d;
      arg_q <= arg_d;
    end
  end

  assign min_o    = min_q;
  assign argmin_o = arg_q;

endmodule

// File: rtl/sequenciador_menor_distancia.sv
// Nearest-template classifier sequencer: walks the templates through a shared
// distance unit, keeps the argmin, and reports the digit or 15 when rejected.
module sequenciador_menor_distancia
  import classificacao_pkg::*;
#(
  parameter int N_CLASSES = N_CLASSES_DEF,  // must not exceed 15
  parameter int DIST_W    = DIST_W_DEF
) (
  input  logic                           iCLK,
  input  logic                           iRST_N,
  sequenciador_menor_distancia_if.slave  bus
);

  localparam logic [3:0] ULTIMO = 4'(N_CLASSES - 1);

  estado_t           state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [DIST_W-1:0] limiar_q, limiar_d;
  logic              req_q, req_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [3:0]        digito_q, digito_d;
  logic [DIST_W-1:0] menor_q, menor_d;

  logic              acc_clr, acc_en;
  logic [DIST_W-1:0] acc_min;
  logic [3:0]        acc_arg;

  acumulador_menor #(
    .DIST_W (DIST_W),
    .IDX_W  (4)
  ) u_acc (
    .clk_i    (iCLK),
    .rst_ni   (iRST_N),
    .clr_i    (acc_clr),
    .en_i     (acc_en),
    .valor_i  (bus.iDist),
    .indice_i (idx_q),
    .min_o    (acc_min),
    .argmin_o (acc_arg)
  );

  // oReq is raised on the edge that enters ISSUE so it lines up with the state.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    limiar_d = limiar_q;
    req_d    = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    digito_d = digito_q;
    menor_d  = menor_q;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.iStart) begin
          state_d  = ISSUE;
          idx_d    = 4'd0;
          limiar_d = bus.iLimiar;
          acc_clr  = 1'b1;
          req_d    = 1'b1;
          busy_d   = 1'b1;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.iDistValid) begin
          acc_en = 1'b1;
          if (idx_q == ULTIMO) begin
            state_d = DECIDE;
          end else begin
            idx_d   = idx_q + 4'd1;
            req_d   = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      DECIDE: begin
        digito_d = (acc_min <= limiar_q) ? acc_arg : DIGITO_INVALIDO;
        menor_d  = acc_min;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= IDLE;
      idx_q    <= 4'd0;
      limiar_q <= '0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      digito_q <= DIGITO_INVALIDO;
      menor_q  <= '1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      limiar_q <= limiar_d;
      req_q    <= req_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      digito_q <= digito_d;
      menor_q  <= menor_d;
    end
  end

  assign bus.oReq       = req_q;
  assign bus.oTemplate  = idx_q;
  assign bus.oBusy      = busy_q;
  assign bus.oDone      = done_q;
  assign bus.oDigito    = digito_q;
  assign bus.oMenorDist = menor_q;

endmodule
